// File: rtl/ifetch_queue.sv
// Fetch unit + 8-deep instruction queue: one word read outstanding, pushed word visible the cycle after mem_done.
// Dispatch pops via inst_valid/inst_ready, issue stalls while full, rdy_in=0 freezes; IF_PREDICT_EN adds static JAL/backward-branch prediction.
module ifetch_queue #(
  parameter int          QUEUE_ADDR_W = 3,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_pred_taken,
  input  logic        inst_ready,
  input  logic        flush_in,
  input  logic [31:0] flush_pc
);
  localparam int DEPTH = 1 << QUEUE_ADDR_W;
  localparam logic [QUEUE_ADDR_W-1:0] PTR_ONE = QUEUE_ADDR_W'(1);
  localparam logic [QUEUE_ADDR_W:0]   CNT_ONE = (QUEUE_ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t                queue [DEPTH];
  logic [QUEUE_ADDR_W-1:0] head, tail;
  logic [QUEUE_ADDR_W:0]   count;
  logic [31:0]           pc, pc_nxt, next_pc, addr_nxt;
  state_t                state, state_nxt;
  logic                  req_nxt, push, pop, full, pred_taken;
  logic                  unused_flush_lsb;

  assign unused_flush_lsb = ^flush_pc[1:0];
  // count never exceeds DEPTH, so its MSB alone marks full.
  assign full = count[QUEUE_ADDR_W];
  assign pop  = inst_valid && inst_ready && !flush_in;

`ifdef IF_PREDICT_EN
  logic        pred_q [DEPTH];
  logic [31:0] j_imm, b_imm;

  assign j_imm = {{12{mem_data[31]}}, mem_data[19:12], mem_data[20], mem_data[30:21], 1'b0};
  assign b_imm = {{20{mem_data[31]}}, mem_data[7], mem_data[30:25], mem_data[11:8], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    next_pc    = pc + 32'd4;
    if (mem_data[6:0] == 7'b1101111) begin
      pred_taken = 1'b1;
      next_pc    = pc + j_imm;
    end else if (mem_data[6:0] == 7'b1100011 && mem_data[31]) begin
      pred_taken = 1'b1;
      next_pc    = pc + b_imm;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) pred_q[tail] <= pred_taken;
  end

  assign inst_pred_taken = inst_valid & pred_q[head];
`else
  assign pred_taken      = 1'b0;
  assign next_pc         = pc + 32'd4;
  assign inst_pred_taken = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    addr_nxt  = mem_addr;
    pc_nxt    = pc;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush_in && !full) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          addr_nxt  = pc;
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          if (!flush_in) begin
            push   = 1'b1;
            pc_nxt = next_pc;
          end
        end else if (flush_in) begin
          // Request already on the bus; its data must be swallowed when it returns.
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (mem_done) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_in) pc_nxt = {flush_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (rdy_in) begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      mem_req  <= req_nxt;
      mem_addr <= addr_nxt;
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_ONE;
        if (pop)  head <= head + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) queue[tail] <= {mem_data, pc};
  end

  assign inst_valid = |count;
  assign inst_out   = inst_valid ? queue[head].inst : 32'h0;
  assign inst_pc    = inst_valid ? queue[head].pc   : 32'h0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a latency-randomized memory responder plus a queue-based reference model
// checked every cycle, with directed phases pinning reset, full, flush, freeze, prediction and push+pop cases.
module tb_ifetch_queue;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JALM8 = 32'hFF9F_F06F;
  localparam logic [31:0] BEQF  = 32'h0000_0463;
  localparam logic [31:0] BNEB  = 32'hFE10_1EE3;
  localparam logic [31:0] JALR  = 32'h0000_8067;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, mem_req, mem_done, inst_valid, inst_pred_taken, inst_ready, flush_in;
  logic [31:0] mem_addr, mem_data, inst_out, inst_pc, flush_pc;

  ifetch_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_pred_taken(inst_pred_taken), .inst_ready(inst_ready),
    .flush_in(flush_in), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] mpc, exp_addr;
  logic        exp_req, outstanding, discard;

  // Memory responder state
  int          mode = 0;
  int          fixed_lat = 2;
  bit          rand_lat = 0;
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [2:0] sel;
    sel = a[4:2] ^ a[7:5];
    if (mode == 0) return NOP;
    if (mode == 2) return (a == 32'h10) ? JALM8 : (a == 32'h8) ? BEQF : NOP;
    case (sel)
      3'd3:    return JALM8;
      3'd4:    return BNEB;
      3'd5:    return BEQF;
      3'd6:    return JALR;
      3'd7:    return {a[11:0] ^ 12'hA53, 8'h00, 5'd0, 7'h6F};
      default: return NOP;
    endcase
  endfunction

  // Static prediction from instruction fields, computed with signed integer arithmetic.
  task automatic predict(input logic [31:0] w, input logic [31:0] p, output logic [31:0] npc, output logic tk);
    int imm;
    npc = p + 32'd4;
    tk  = 1'b0;
    imm = 0;
`ifdef IF_PREDICT_EN
    if (w[6:0] == 7'h6F) begin
      imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096 - (w[31] ? 1048576 : 0);
      npc = p + imm;
      tk  = 1'b1;
    end else if (w[6:0] == 7'h63 && w[31]) begin
      imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - 4096;
      npc = p + imm;
      tk  = 1'b1;
    end
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = 32'h0; exp_addr = 32'h0; exp_req = 1'b0; outstanding = 1'b0; discard = 1'b0;
  endtask

  task automatic model_step();
    ent_t        e;
    logic [31:0] npc;
    logic        tk;
    bit          do_pop, can_issue;
    if (!rdy_in) return;
    do_pop    = (mq.size() != 0) && inst_ready && !flush_in;
    can_issue = !outstanding && !flush_in && (mq.size() < 8);
    if (do_pop) void'(mq.pop_front());
    if (outstanding) begin
      if (mem_done) begin
        outstanding = 1'b0;
        exp_req     = 1'b0;
        if (!discard && !flush_in) begin
          predict(mem_data, mpc, npc, tk);
          e.inst = mem_data; e.pc = mpc; e.pred = tk;
          mq.push_back(e);
          mpc = npc;
        end
        discard = 1'b0;
      end else if (flush_in) begin
        discard = 1'b1;
      end
    end else if (can_issue) begin
      outstanding = 1'b1;
      exp_req     = 1'b1;
      exp_addr    = mpc;
    end
    if (flush_in) begin
      mq.delete();
      mpc = {flush_pc[31:2], 2'b00};
    end
  endtask

  task automatic mem_respond();
    mem_done = 1'b0;
    mem_data = $urandom;
    if (!rdy_in) return;
    if (!mem_pend && mem_req) begin
      mem_pend = 1;
      mem_a    = mem_addr;
      mem_cnt  = rand_lat ? $urandom_range(0, 3) : fixed_lat;
    end
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        mem_done = 1'b1;
        mem_data = mem_word(mem_a);
        mem_pend = 0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic compare();
    logic v;
    v = mq.size() != 0;
    check("model_mem_req", {31'd0, mem_req}, {31'd0, exp_req});
    check("model_mem_addr", mem_addr, exp_addr);
    check("model_inst_valid", {31'd0, inst_valid}, {31'd0, v});
    if (v) begin
      check("model_inst_out", inst_out, mq[0].inst);
      check("model_inst_pc", inst_pc, mq[0].pc);
      check("model_pred", {31'd0, inst_pred_taken}, {31'd0, mq[0].pred});
    end else begin
      check("model_inst_out_empty", inst_out, 32'h0);
      check("model_inst_pc_empty", inst_pc, 32'h0);
      check("model_pred_empty", {31'd0, inst_pred_taken}, 32'h0);
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge after comparing.
  task automatic tick();
    mem_respond();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    compare();
  endtask

  task automatic wait_req(input logic lvl);
    for (int i = 0; i < 200; i++) begin
      if (mem_req === lvl) return;
      tick();
    end
    n_checks++; n_fail++;
    $display("FAIL wait_mem_req: got %0b expected %0b within 200 cycles", mem_req, lvl);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200; i++) begin
      if (inst_valid === 1'b1) return;
      tick();
    end
    n_checks++; n_fail++;
    $display("FAIL wait_inst_valid: got 0 expected 1 within 200 cycles");
  endtask

  initial begin
    int p_ready;
    rst_in = 1'b1; rdy_in = 1'b1; inst_ready = 1'b0; flush_in = 1'b0; flush_pc = 32'h0;
    mem_done = 1'b0; mem_data = 32'h0;
    model_reset();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    compare();
    check("reset_mem_req", {31'd0, mem_req}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_inst_valid", {31'd0, inst_valid}, 32'h0);
    check("reset_inst_out", inst_out, 32'h0);

    // First fetch from RESET_PC, three-cycle memory
    wait_req(1'b1);
    check("first_addr", mem_addr, 32'h0);
    wait_valid();
    check("first_inst", inst_out, 32'h13);
    check("first_pc", inst_pc, 32'h0);
    wait_req(1'b1);
    check("second_addr", mem_addr, 32'h4);

    // Fill to 8 with dispatch stalled; no issue while full
    for (int i = 0; i < 200 && mq.size() != 8; i++) tick();
    repeat (4) tick();
    check("full_no_req", {31'd0, mem_req}, 32'h0);
    check("full_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    check("pop_head_pc", inst_pc, 32'h4);
    wait_req(1'b1);
    check("after_pop_addr", mem_addr, 32'h20);

    // Flush while the fetch is pending: returned word must be dropped
    flush_in = 1'b1; flush_pc = 32'h103; tick(); flush_in = 1'b0;
    check("flush_empty", {31'd0, inst_valid}, 32'h0);
    wait_req(1'b0);
    wait_req(1'b1);
    check("flush_addr", mem_addr, 32'h100);
    check("flush_still_empty", {31'd0, inst_valid}, 32'h0);

    // Global freeze during WAIT
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("freeze_req", {31'd0, mem_req}, 32'h1);
      check("freeze_addr", mem_addr, 32'h100);
    end
    rdy_in = 1'b1;
    wait_valid();
    check("unfreeze_pc", inst_pc, 32'h100);
    check("unfreeze_inst", inst_out, 32'h13);

    // Static prediction: JAL -8 at 0x10, forward BEQ at 0x8
    mode = 2;
    flush_in = 1'b1; flush_pc = 32'h10; tick(); flush_in = 1'b0;
    wait_valid();
    check("jal_pc", inst_pc, 32'h10);
    check("jal_inst", inst_out, JALM8);
`ifdef IF_PREDICT_EN
    check("jal_pred", {31'd0, inst_pred_taken}, 32'h1);
    wait_req(1'b1);
    check("jal_target", mem_addr, 32'h8);
    wait_req(1'b0);
    wait_req(1'b1);
    check("beq_fwd_next", mem_addr, 32'hC);
`else
    check("jal_pred", {31'd0, inst_pred_taken}, 32'h0);
    wait_req(1'b1);
    check("jal_target", mem_addr, 32'h14);
    wait_req(1'b0);
    wait_req(1'b1);
    check("seq_next", mem_addr, 32'h18);
`endif

    // Single entry: push and pop in the same cycle
    mode = 0;
    flush_in = 1'b1; flush_pc = 32'h200; tick(); flush_in = 1'b0;
    wait_valid();
    for (int i = 0; i < 200 && !(mem_req && mem_pend && mem_cnt == 0); i++) tick();
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    check("pushpop_valid", {31'd0, inst_valid}, 32'h1);
    check("pushpop_pc", inst_pc, 32'h204);

    // Randomized traffic
    mode = 1; rand_lat = 1; p_ready = 2;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) p_ready = $urandom_range(0, 4);
      rdy_in     = ($urandom_range(0, 9) != 0);
      inst_ready = ($urandom_range(0, 3) < p_ready);
      flush_in   = ($urandom_range(0, 39) == 0);
      flush_pc   = $urandom & 32'h0000_03FF;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
